// File: rtl/clkmon_burst_gen.sv
// Clock-monitor burst generator: drives a square-wave burst of a programmed
// number of rising edges onto one of two monitor pins (user or core clock).
// Half-period and edge count are latched at the request handshake.
// Optional build macro: CLKMON_FREERUN_EN -- when defined, a request with
// cfg_count = 0 free-runs until abort or reset and edge_cnt wraps.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for a request, cfg_ready high, pins low, oeb = 2'b11
// LOW   | selected pin low for div+1 cycles
// HIGH  | selected pin high for div+1 cycles, edge counted on entry
// DONE  | one-cycle completion pulse, pin low, then back to IDLE
module clkmon_burst_gen #(
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             cfg_sel,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_count,
  input  logic             abort,
  output logic             mon_user_o,
  output logic             mon_core_o,
  output logic [1:0]       mon_oeb_o,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] edge_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               sel_q, sel_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [DIV_W-1:0]   tmr_q, tmr_d;
  logic [CNT_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic               mon_user_q, mon_user_d;
  logic               mon_core_q, mon_core_d;
  logic [1:0]         oeb_q, oeb_d;
  logic               done_q, done_d;

  logic               handshake;
  logic               last_edge;
  logic               zero_to_done;

  // Burst termination rule; a zero count either free-runs or completes at once.
  always_comb begin
`ifdef CLKMON_FREERUN_EN
    last_edge    = (count_q != '0) && (edge_cnt_q == count_q);
    zero_to_done = 1'b0;
`else
    last_edge    = (edge_cnt_q == count_q);
    zero_to_done = 1'b1;
`endif
  end

  // abort beats a simultaneous request in IDLE
  assign handshake = cfg_valid && (state_q == ST_IDLE) && !abort;

  // Next-state, timer, counter and registered-output decode.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    div_d      = div_q;
    count_d    = count_q;
    tmr_d      = tmr_q;
    edge_cnt_d = edge_cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (handshake) begin
          sel_d      = cfg_sel;
          div_d      = cfg_div;
          count_d    = cfg_count;
          tmr_d      = cfg_div;
          edge_cnt_d = '0;
          state_d    = ((cfg_count == '0) && zero_to_done) ? ST_DONE : ST_LOW;
        end
      end
      ST_LOW: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          state_d    = ST_HIGH;
          tmr_d      = div_q;
          edge_cnt_d = edge_cnt_q + CNT_W'(1);
        end else begin
          tmr_d = tmr_q - DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (tmr_q == '0) begin
          tmr_d   = div_q;
          state_d = last_edge ? ST_DONE : ST_LOW;
        end else begin
          tmr_d = tmr_q - DIV_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Pins, enables and done follow the next state so they line up with it.
    mon_user_d = (state_d == ST_HIGH) && !sel_d;
    mon_core_d = (state_d == ST_HIGH) &&  sel_d;
    oeb_d      = 2'b11;
    if (state_d != ST_IDLE) begin
      oeb_d[sel_d] = 1'b0;
    end
    done_d = (state_d == ST_DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      sel_q      <= 1'b0;
      div_q      <= '0;
      count_q    <= '0;
      tmr_q      <= '0;
      edge_cnt_q <= '0;
      mon_user_q <= 1'b0;
      mon_core_q <= 1'b0;
      oeb_q      <= 2'b11;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      div_q      <= div_d;
      count_q    <= count_d;
      tmr_q      <= tmr_d;
      edge_cnt_q <= edge_cnt_d;
      mon_user_q <= mon_user_d;
      mon_core_q <= mon_core_d;
      oeb_q      <= oeb_d;
      done_q     <= done_d;
    end
  end

  assign cfg_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q == ST_LOW) || (state_q == ST_HIGH);
  assign mon_user_o = mon_user_q;
  assign mon_core_o = mon_core_q;
  assign mon_oeb_o  = oeb_q;
  assign done       = done_q;
  assign edge_cnt   = edge_cnt_q;

endmodule
